// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver / reader and the receive FIFO.
// The master drives received bytes and pop strobes; the FIFO (slave) returns the head entry.
interface uart_rx_fifo_if;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_ferr_i;
    logic       rx_perr_i;
    logic       rd_en_i;
    logic [7:0] rd_data_o;
    logic       rd_ferr_o;
    logic       rd_perr_o;
    logic       empty_o;

    modport master (
        output rx_data_i, rx_valid_i, rx_ferr_i, rx_perr_i, rd_en_i,
        input  rd_data_o, rd_ferr_o, rd_perr_o, empty_o
    );

    modport slave (
        input  rx_data_i, rx_valid_i, rx_ferr_i, rx_perr_i, rd_en_i,
        output rd_data_o, rd_ferr_o, rd_perr_o, empty_o
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT FIFO for the UART: stores {perr, ferr, data}, tracks overrun,
// and raises level-threshold and character-timeout interrupts.
module uart_rx_fifo #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = 4,
    parameter int unsigned TO_TICKS = 640
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_rx_fifo_if.slave        bus,
    input  logic [15:0]          baud_div,
    input  logic                 flush_i,
    input  logic                 ovr_clr_i,
    input  logic [AW:0]          thresh_i,
    output logic                 full_o,
    output logic [AW:0]          level_o,
    output logic                 overrun_o,
    output logic                 thr_irq_o,
    output logic                 timeout_irq_o
);

    localparam logic [AW:0] DepthL = (AW + 1)'(DEPTH);
    localparam logic [15:0] ToMax  = 16'(TO_TICKS);

    logic [9:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic          overrun_q;
    logic [15:0]   div_q;
    logic [15:0]   to_cnt_q;
    logic          to_irq_q;

    logic empty, full, push_ok, pop_ok, ovr_set, tick, to_clr;

    always_comb begin
        empty   = (level_q == '0);
        full    = (level_q == DepthL);
        // A pop frees the slot in the same cycle, so a full FIFO still accepts a push with a pop.
        push_ok = bus.rx_valid_i && (!full || bus.rd_en_i) && !flush_i;
        pop_ok  = bus.rd_en_i && !empty && !flush_i;
        ovr_set = bus.rx_valid_i && full && !bus.rd_en_i && !flush_i;
        tick    = (div_q == 16'd0);
        to_clr  = flush_i || push_ok || pop_ok || empty;
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {bus.rx_perr_i, bus.rx_ferr_i, bus.rx_data_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok) begin
                level_q <= level_q + (AW + 1)'(1);
            end else if (pop_ok && !push_ok) begin
                level_q <= level_q - (AW + 1)'(1);
            end
        end
    end

    // Set wins over clear; flush leaves the sticky flag alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (ovr_set) begin
            overrun_q <= 1'b1;
        end else if (ovr_clr_i) begin
            overrun_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= 16'd0;
        end else if (tick) begin
            div_q <= baud_div;
        end else begin
            div_q <= div_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= 16'd0;
            to_irq_q <= 1'b0;
        end else begin
            if (to_clr) begin
                to_cnt_q <= 16'd0;
            end else if (tick && to_cnt_q != ToMax) begin
                to_cnt_q <= to_cnt_q + 16'd1;
            end
            if (flush_i || pop_ok) begin
                to_irq_q <= 1'b0;
            end else if (!to_clr && tick && to_cnt_q == ToMax - 16'd1) begin
                to_irq_q <= 1'b1;
            end
        end
    end

    logic [9:0] head;
    assign head          = mem_q[rd_ptr_q];
    assign bus.rd_data_o = head[7:0];
    assign bus.rd_ferr_o = head[8];
    assign bus.rd_perr_o = head[9];
    assign bus.empty_o   = empty;
    assign full_o        = full;
    assign level_o       = level_q;
    assign overrun_o     = overrun_q;
    assign thr_irq_o     = (thresh_i != '0) && (level_q >= thresh_i);
    assign timeout_irq_o = to_irq_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: accepted pushes queue expected entries,
// a negedge monitor checks every accepted pop against the queue head.
module tb_uart_rx_fifo;
    localparam int AW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] baud_div = 16'd0;
    logic        flush_i = 1'b0;
    logic        ovr_clr_i = 1'b0;
    logic [AW:0] thresh_i = '0;
    logic        full_o, overrun_o, thr_irq_o, timeout_irq_o;
    logic [AW:0] level_o;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(.DEPTH(16), .AW(AW), .TO_TICKS(640)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .baud_div      (baud_div),
        .flush_i       (flush_i),
        .ovr_clr_i     (ovr_clr_i),
        .thresh_i      (thresh_i),
        .full_o        (full_o),
        .level_o       (level_o),
        .overrun_o     (overrun_o),
        .thr_irq_o     (thr_irq_o),
        .timeout_irq_o (timeout_irq_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [9:0] sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: an accepted pop is visible at negedge as rd_en with a non-empty head.
    always @(negedge clk) begin
        if (rst_n && !flush_i && bus.rd_en_i && !bus.empty_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_underflow: got 0x%0h expected none",
                         {bus.rd_perr_o, bus.rd_ferr_o, bus.rd_data_o});
            end else begin
                chk("pop_entry", {22'd0, bus.rd_perr_o, bus.rd_ferr_o, bus.rd_data_o},
                    {22'd0, sb.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic f, input logic p, input bit acc);
        bus.rx_data_i  = d;
        bus.rx_ferr_i  = f;
        bus.rx_perr_i  = p;
        bus.rx_valid_i = 1'b1;
        if (acc) sb.push_back({p, f, d});
        step();
        bus.rx_valid_i = 1'b0;
    endtask

    task automatic pop();
        bus.rd_en_i = 1'b1;
        step();
        bus.rd_en_i = 1'b0;
    endtask

    task automatic push_pop(input logic [7:0] d);
        bus.rx_data_i  = d;
        bus.rx_ferr_i  = 1'b0;
        bus.rx_perr_i  = 1'b0;
        bus.rx_valid_i = 1'b1;
        bus.rd_en_i    = 1'b1;
        sb.push_back({2'b00, d});
        step();
        bus.rx_valid_i = 1'b0;
        bus.rd_en_i    = 1'b0;
    endtask

    initial begin
        int n;
        bus.rx_data_i = 8'h00;
        bus.rx_valid_i = 1'b0;
        bus.rx_ferr_i = 1'b0;
        bus.rx_perr_i = 1'b0;
        bus.rd_en_i = 1'b0;
        #23 rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_empty", 32'(bus.empty_o), 1);
        chk("rst_full", 32'(full_o), 0);
        chk("rst_level", 32'(level_o), 0);
        chk("rst_overrun", 32'(overrun_o), 0);
        chk("rst_timeout", 32'(timeout_irq_o), 0);

        // Single entry with framing error
        push(8'hA5, 1'b1, 1'b0, 1'b1);
        chk("one_empty", 32'(bus.empty_o), 0);
        chk("one_level", 32'(level_o), 1);
        chk("one_data", 32'(bus.rd_data_o), 32'hA5);
        chk("one_ferr", 32'(bus.rd_ferr_o), 1);
        chk("one_perr", 32'(bus.rd_perr_o), 0);
        pop();
        chk("one_empty_after", 32'(bus.empty_o), 1);

        // Push with pop on empty: only the push happens
        push_pop(8'h3C);
        chk("pp_empty_level", 32'(level_o), 1);
        pop();

        // Fill, overrun, drain in order
        for (int i = 0; i < 16; i++) push(8'(i), 1'(i == 3), 1'(i == 9), 1'b1);
        push(8'hFF, 1'b0, 1'b0, 1'b0);
        chk("fill_full", 32'(full_o), 1);
        chk("fill_overrun", 32'(overrun_o), 1);
        chk("fill_level", 32'(level_o), 16);
        for (int i = 0; i < 16; i++) pop();
        chk("drain_empty", 32'(bus.empty_o), 1);
        chk("ovr_sticky", 32'(overrun_o), 1);
        ovr_clr_i = 1'b1;
        step();
        ovr_clr_i = 1'b0;
        chk("ovr_clear", 32'(overrun_o), 0);

        // Push and pop together while full
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i), 1'b0, 1'b0, 1'b1);
        push_pop(8'h55);
        chk("full_pp_level", 32'(level_o), 16);
        chk("full_pp_ovr", 32'(overrun_o), 0);
        for (int i = 0; i < 16; i++) pop();
        chk("full_pp_empty", 32'(bus.empty_o), 1);

        // Threshold interrupt
        thresh_i = 5'd4;
        for (int i = 0; i < 3; i++) push(8'h40 + 8'(i), 1'b0, 1'b0, 1'b1);
        chk("thr_below", 32'(thr_irq_o), 0);
        push(8'h43, 1'b0, 1'b0, 1'b1);
        chk("thr_at", 32'(thr_irq_o), 1);
        pop();
        chk("thr_after_pop", 32'(thr_irq_o), 0);
        thresh_i = 5'd0;
        #1;
        chk("thr_disabled", 32'(thr_irq_o), 0);
        for (int i = 0; i < 3; i++) pop();

        // Character timeout with a tick every cycle
        push(8'hB7, 1'b0, 1'b1, 1'b1);
        n = 0;
        while (!timeout_irq_o && n < 2000) begin
            step();
            n++;
        end
        chk("to_latency", 32'(n), 640);
        pop();
        chk("to_clr_pop", 32'(timeout_irq_o), 0);
        for (int i = 0; i < 700; i++) step();
        chk("to_empty_idle", 32'(timeout_irq_o), 0);

        // Flush with a simultaneous incoming byte
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 1'b0, 1'b0, 1'b1);
        flush_i = 1'b1;
        bus.rx_data_i = 8'hEE;
        bus.rx_valid_i = 1'b1;
        step();
        flush_i = 1'b0;
        bus.rx_valid_i = 1'b0;
        sb.delete();
        chk("flush_level", 32'(level_o), 0);
        chk("flush_empty", 32'(bus.empty_o), 1);
        chk("flush_ovr", 32'(overrun_o), 0);
        push(8'h71, 1'b0, 1'b0, 1'b1);
        chk("post_flush_head", 32'(bus.rd_data_o), 32'h71);

        // Asynchronous reset mid-stream
        push(8'h72, 1'b0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_level", 32'(level_o), 0);
        chk("arst_empty", 32'(bus.empty_o), 1);
        chk("arst_full", 32'(full_o), 0);
        #10 rst_n = 1'b1;
        step();
        chk("sb_drained", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
